// File: rtl/stream_rr_sel.sv
// Round-robin select generator for a stream mux: picks a fair input index and
// holds it while the mux output is stalled or, optionally, until a packet ends.
module stream_rr_sel #(
   parameter int          N_INP     = 2,
   parameter bit          LOCK_PKT  = 1'b0,
   parameter int unsigned LOG_N_INP = (N_INP > 1) ? $clog2(N_INP) : 1
) (
   input  logic                 clk_i,
   input  logic                 rst_i,
   input  logic [N_INP-1:0]     inp_valid_i,
   input  logic [N_INP-1:0]     inp_last_i,
   input  logic                 oup_ready_i,
   output logic [LOG_N_INP-1:0] sel_o,
   output logic                 locked_o
);

   logic [LOG_N_INP-1:0] ptr_q;
   logic [LOG_N_INP-1:0] sel_q;
   logic                 lock_q;
   logic [LOG_N_INP-1:0] arb_sel;
   logic [LOG_N_INP-1:0] ptr_nxt;
   logic                 sel_vld;
   logic                 sel_last;
   logic                 hs;
   logic                 end_txn;
   logic                 hold;

   // Scan from the farthest offset down so the nearest valid input wins.
   always_comb begin
      arb_sel = ptr_q;
      for (int k = N_INP - 1; k >= 0; k--) begin
         int idx;
         idx = int'(ptr_q) + k;
         if (idx >= N_INP) idx = idx - N_INP;
         if (inp_valid_i[idx]) arb_sel = LOG_N_INP'(idx);
      end
   end

   assign sel_o    = lock_q ? sel_q : arb_sel;
   assign locked_o = lock_q;

   assign sel_vld  = inp_valid_i[sel_o];
   assign sel_last = inp_last_i[sel_o];
   assign hs       = sel_vld & oup_ready_i;
   assign end_txn  = hs & (!LOCK_PKT | sel_last);
   // A stall, or an accepted non-last beat in packet mode, freezes the grant.
   assign hold     = (sel_vld & !oup_ready_i) | (hs & LOCK_PKT & !sel_last);

   assign ptr_nxt  = (int'(sel_o) == N_INP - 1) ? '0 : sel_o + LOG_N_INP'(1);

   always_ff @(posedge clk_i) begin
      if (rst_i) begin
         ptr_q  <= '0;
         lock_q <= 1'b0;
         sel_q  <= '0;
      end else if (end_txn) begin
         lock_q <= 1'b0;
         ptr_q  <= ptr_nxt;
      end else if (hold) begin
         lock_q <= 1'b1;
         sel_q  <= sel_o;
      end
   end

`ifndef SYNTHESIS
   always_ff @(posedge clk_i) begin
      if (!rst_i) begin
         assert (N_INP >= 1)
            else $error("stream_rr_sel: N_INP must be >= 1");
         assert (int'(sel_o) < N_INP)
            else $error("stream_rr_sel: sel_o %0d out of range", sel_o);
         assert (LOCK_PKT || !lock_q || inp_valid_i[sel_q])
            else $error("stream_rr_sel: held input dropped valid while locked");
      end
   end
`endif

endmodule
